// File: rtl/stage_execute.sv
// Execute stage: runs INC/DEC as a read-modify-write on the data tape and LEFT/RIGHT on the data pointer.
// Define STAGE_EXECUTE_CELL_CACHE_EN to keep the last written cell so back-to-back INC/DEC skip the read.
`timescale 1ns/1ps

`ifndef OPCODE_MSB
`define OPCODE_MSB 2
`endif
`ifndef OP_INC
`define OP_INC 3'd1
`endif
`ifndef OP_DEC
`define OP_DEC 3'd2
`endif
`ifndef OP_LEFT
`define OP_LEFT 3'd3
`endif
`ifndef OP_RIGHT
`define OP_RIGHT 3'd4
`endif

module stage_execute #(
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [`OPCODE_MSB:0]    operation_in,
  input  logic                    drdy_in,
  output logic                    ack,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic                    mem_we,
  output logic                    mem_req,
  input  logic                    mem_ack,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  output logic [ADDR_WIDTH-1:0]   dp
);

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_ACK} state_e;

  state_e                  state_q, state_d;
  logic [`OPCODE_MSB:0]    op_q, op_d;
  logic [ADDR_WIDTH-1:0]   dp_q, dp_d;
  logic [DATA_WIDTH-1:0]   cell_q, cell_d;
  logic                    cvld_q, cvld_d;
  logic                    ack_q, ack_d;
  logic                    req_q, req_d;
  logic                    we_q, we_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;

  logic [DATA_WIDTH-1:0]   cached_step, read_step;
  logic                    cache_keep;

  function automatic logic [DATA_WIDTH-1:0] step(input logic [DATA_WIDTH-1:0] v, input logic dec);
    return dec ? v - 1'b1 : v + 1'b1;
  endfunction

  assign cached_step = step(cell_q, operation_in == `OP_DEC);
  assign read_step   = step(mem_rdata, op_q == `OP_DEC);

`ifdef STAGE_EXECUTE_CELL_CACHE_EN
  assign cache_keep = 1'b1;
`else
  assign cache_keep = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    dp_d    = dp_q;
    cell_d  = cell_q;
    cvld_d  = cvld_q;
    ack_d   = ack_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      S_IDLE: begin
        if (drdy_in) begin
          op_d = operation_in;
          case (operation_in)
            `OP_INC, `OP_DEC: begin
              req_d  = 1'b1;
              addr_d = dp_q;
              if (cvld_q) begin
                cell_d  = cached_step;
                wdata_d = cached_step;
                we_d    = 1'b1;
                state_d = S_WR;
              end else begin
                we_d    = 1'b0;
                state_d = S_RD;
              end
            end
            `OP_LEFT: begin
              dp_d    = dp_q - 1'b1;
              cvld_d  = 1'b0;
              state_d = S_ACK;
            end
            `OP_RIGHT: begin
              dp_d    = dp_q + 1'b1;
              cvld_d  = 1'b0;
              state_d = S_ACK;
            end
            default: state_d = S_ACK;
          endcase
        end
      end
      // Request stays up from read into write; the we flip marks the new access.
      S_RD: begin
        if (mem_ack) begin
          cell_d  = read_step;
          wdata_d = read_step;
          we_d    = 1'b1;
          state_d = S_WR;
        end
      end
      S_WR: begin
        if (mem_ack) begin
          req_d   = 1'b0;
          we_d    = 1'b0;
          cvld_d  = cache_keep;
          state_d = S_ACK;
        end
      end
      S_ACK: begin
        if (!ack_q) begin
          ack_d = 1'b1;
        end else if (!drdy_in) begin
          ack_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      dp_q    <= '0;
      cell_q  <= '0;
      cvld_q  <= 1'b0;
      ack_q   <= 1'b0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      dp_q    <= dp_d;
      cell_q  <= cell_d;
      cvld_q  <= cvld_d;
      ack_q   <= ack_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign ack       = ack_q;
  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign dp        = dp_q;

endmodule
